mem_port_arbiter: RTL and testbench

- Shares the single-ported unified memory between the instruction-fetch (IF) requester and the data-access (MEM stage) requester of the pipelined RV32I core.
- Sequences one memory transaction at a time over a req/ack handshake with variable latency.
- Returns read data and a completion pulse to the winning requester. The pipeline uses these pulses to generate its stalls.
- Data accesses have priority. A burst limit guarantees that fetch cannot be starved.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter_arb_prio_burst.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 94 +++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Common definitions shared by the memory port arbiter, its interface and its sub-blocks.
// Holds the FSM state type, access encodings and a saturating-increment helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

  function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
    return (value >= limit) ? limit : value + 4'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the unified memory port.
// The master modport is the arbiter's view; slave is the view of the core and memory around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem_port_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_rw;
  logic [1:0]        d_size;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rw;
  logic [1:0]        mem_size;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr,
    output if_done, if_rdata,
    input  d_req, d_addr, d_wdata, d_rw, d_size,
    output d_done, d_rdata,
    output mem_req, mem_addr, mem_wdata, mem_rw, mem_size,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_done, if_rdata,
    output d_req, d_addr, d_wdata, d_rw, d_size,
    input  d_done, d_rdata,
    input  mem_req, mem_addr, mem_wdata, mem_rw, mem_size,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_arb_prio_burst.sv
// Winner select for the memory port: data first, except when fetch has waited out a full data burst.
// Also keeps the count of consecutive data grants made while fetch was waiting.
module arb_prio_burst
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_BURST = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       arb_en,
  input  logic       if_req,
  input  logic       d_req,
  output logic       grant_i,
  output logic       grant_d,
  output logic [3:0] burst_cnt
);

  localparam logic [3:0] BURST_LIM = 4'(MAX_D_BURST);

  logic fetch_starved;

  assign fetch_starved = if_req && (burst_cnt == BURST_LIM);

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (arb_en) begin
      if (d_req && !fetch_starved) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_i = 1'b1;
      end
    end
  end

  // Only arbitration cycles move the counter; the busy phase leaves it alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      burst_cnt <= 4'd0;
    end else if (arb_en) begin
      if (grant_i || !if_req) begin
        burst_cnt <= 4'd0;
      end else if (grant_d) begin
        burst_cnt <= sat_inc(burst_cnt, BURST_LIM);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified memory between instruction fetch and the MEM stage.
// One transaction at a time; the winner's fields are latched onto the memory bus until mem_ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_port_arbiter_if.master   bus
);

  arb_state_t state;
  logic       arb_en;
  logic       grant_i;
  logic       grant_d;
  logic [3:0] burst_cnt;

  // The IDLE cycle carrying a done pulse is the mandatory gap: the finishing requester still has req high.
  assign arb_en = (state == IDLE) && !bus.if_done && !bus.d_done;

  arb_prio_burst #(
    .MAX_D_BURST (MAX_D_BURST)
  ) u_arb (
    .clock     (clock),
    .reset     (reset),
    .arb_en    (arb_en),
    .if_req    (bus.if_req),
    .d_req     (bus.d_req),
    .grant_i   (grant_i),
    .grant_d   (grant_d),
    .burst_cnt (burst_cnt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.mem_rw    <= RW_LOAD;
      bus.mem_size  <= SIZE_B;
      bus.if_done   <= 1'b0;
      bus.d_done    <= 1'b0;
      bus.if_rdata  <= {DATA_W{1'b0}};
      bus.d_rdata   <= {DATA_W{1'b0}};
    end else begin
      bus.if_done <= 1'b0;
      bus.d_done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            state         <= BUSY_D;
            bus.mem_req   <= 1'b1;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            bus.mem_rw    <= bus.d_rw;
            bus.mem_size  <= bus.d_size;
          end else if (grant_i) begin
            state         <= BUSY_I;
            bus.mem_req   <= 1'b1;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= {DATA_W{1'b0}};
            bus.mem_rw    <= RW_LOAD;
            bus.mem_size  <= SIZE_W;
          end
        end
        BUSY_I: begin
          if (bus.mem_ack) begin
            state        <= IDLE;
            bus.mem_req  <= 1'b0;
            bus.if_done  <= 1'b1;
            bus.if_rdata <= bus.mem_rdata;
          end
        end
        BUSY_D: begin
          if (bus.mem_ack) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
            bus.d_done  <= 1'b1;
            bus.d_rdata <= bus.mem_rdata;
          end
        end
        default: begin
          state       <= IDLE;
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset abort, single fetch/store, priority, burst limit, zero-wait cadence.
// A small memory responder answers mem_req; a monitor logs grants and done pulses by cycle number.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clock;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MAX_D_BURST (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int          ack_mode    = 0;
  int          wait_cycles = 0;
  logic [31:0] rdata_val   = 32'h0;

  int cyc         = 0;
  int if_done_cnt = 0;
  int d_done_cnt  = 0;
  int done_cyc_q[$];
  int grant_kind_q[$];
  int grant_cyc_q[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Memory model: acks after wait_cycles in mode 0, holds ack high permanently in mode 2
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clock);
      bus.mem_rdata = rdata_val;
      if (ack_mode == 2) begin
        bus.mem_ack = 1'b1;
      end else if (bus.mem_req && !bus.mem_ack) begin
        if (wait_cnt >= wait_cycles) begin
          bus.mem_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        if (!bus.mem_req) wait_cnt = 0;
      end
    end
  end

  // Monitor: grant kind is taken from address bit 13 (data addresses live at 0x2000 and up)
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (bus.if_done) begin
        if_done_cnt++;
        done_cyc_q.push_back(cyc);
      end
      if (bus.d_done) begin
        d_done_cnt++;
        done_cyc_q.push_back(cyc);
      end
      if (bus.mem_req && !prev_req) begin
        grant_kind_q.push_back(int'(bus.mem_addr[13]));
        grant_cyc_q.push_back(cyc);
      end
      prev_req = bus.mem_req;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, " state"},     32'(dut.state),       32'(IDLE));
    check_output({tag, " mem_req"},   32'(bus.mem_req),     32'd0);
    check_output({tag, " mem_addr"},  bus.mem_addr,         32'd0);
    check_output({tag, " mem_wdata"}, bus.mem_wdata,        32'd0);
    check_output({tag, " mem_rw"},    32'(bus.mem_rw),      32'd0);
    check_output({tag, " mem_size"},  32'(bus.mem_size),    32'd0);
    check_output({tag, " dones"},     {30'd0, bus.if_done, bus.d_done}, 32'd0);
    check_output({tag, " if_rdata"},  bus.if_rdata,         32'd0);
    check_output({tag, " d_rdata"},   bus.d_rdata,          32'd0);
    check_output({tag, " burst_cnt"}, 32'(dut.u_arb.burst_cnt), 32'd0);
  endtask

  // One complete transaction from a single requester, watching the latched bus fields every busy cycle
  task automatic apply_stimulus(input string tag, input bit is_data, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit rw, input logic [1:0] size,
                                input logic [31:0] rdata);
    int  if0;
    int  d0;
    bit  got;
    bit  field_bad;
    logic       exp_rw;
    logic [1:0] exp_size;
    if0 = if_done_cnt;
    d0  = d_done_cnt;
    got = 1'b0;
    field_bad = 1'b0;
    exp_rw   = is_data ? rw : RW_LOAD;
    exp_size = is_data ? size : SIZE_W;
    rdata_val = rdata;
    if (is_data) begin
      bus.d_req = 1'b1; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_rw = rw; bus.d_size = size;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (bus.mem_req) begin
        if (bus.mem_addr !== addr || bus.mem_rw !== exp_rw || bus.mem_size !== exp_size) field_bad = 1'b1;
        if (is_data && bus.mem_wdata !== wdata) field_bad = 1'b1;
      end
      if (is_data ? bus.d_done : bus.if_done) got = 1'b1;
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();
    check_output({tag, " done seen"},    32'(got),       32'd1);
    check_output({tag, " mem fields"},   32'(field_bad), 32'd0);
    check_output({tag, " rdata"},        is_data ? bus.d_rdata : bus.if_rdata, rdata);
    check_output({tag, " own done cnt"}, is_data ? d_done_cnt - d0 : if_done_cnt - if0, 32'd1);
    check_output({tag, " other done"},   is_data ? if_done_cnt - if0 : d_done_cnt - d0, 32'd0);
    check_output({tag, " no regrant"},   32'(bus.mem_req), 32'd0);
  endtask

  initial begin
    int d0;
    int c0;
    int seen;
    bit got;
    int exp_kind[6];

    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.d_rw = 1'b0; bus.d_size = 2'b00;
    tick(); tick(); tick();
    check_idle_outputs("reset held");
    reset = 1'b0;
    tick(); tick();
    check_idle_outputs("after reset");

    $display("[TB] test 1: reset during BUSY_D");
    wait_cycles = 100;
    d0 = d_done_cnt;
    bus.d_req = 1'b1; bus.d_addr = 32'h0000_3000; bus.d_wdata = 32'h1111_2222;
    bus.d_rw = RW_STORE; bus.d_size = SIZE_W;
    tick(); tick();
    check_output("t1 busy mem_req", 32'(bus.mem_req), 32'd1);
    check_output("t1 busy state",   32'(dut.state),   32'(BUSY_D));
    reset = 1'b1;
    #1;
    check_output("t1 async drop mem_req", 32'(bus.mem_req), 32'd0);
    bus.d_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    check_output("t1 no d_done", d_done_cnt - d0, 32'd0);
    check_idle_outputs("t1 released");

    $display("[TB] test 2: fetch only, two wait cycles");
    wait_cycles = 2;
    apply_stimulus("t2 fetch", 1'b0, 32'h0000_0010, 32'h0, 1'b0, SIZE_W, 32'h00A0_0093);

    $display("[TB] test 3: half-word store");
    wait_cycles = 1;
    apply_stimulus("t3 store", 1'b1, 32'h0000_2004, 32'hDEAD_BEEF, RW_STORE, SIZE_H, 32'h1234_5678);

    $display("[TB] test 3b: byte load");
    wait_cycles = 0;
    apply_stimulus("t3b load", 1'b1, 32'h0000_2007, 32'h0, RW_LOAD, SIZE_B, 32'h0000_00C3);

    $display("[TB] test 4: simultaneous requests");
    grant_kind_q.delete(); grant_cyc_q.delete();
    wait_cycles = 1;
    rdata_val = 32'h0BAD_F00D;
    d0 = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
    bus.d_req = 1'b1; bus.d_addr = 32'h0000_2008; bus.d_rw = RW_LOAD; bus.d_size = SIZE_W;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (bus.d_done) begin
        bus.d_req = 1'b0;
        d0 = cyc;
      end
      if (bus.if_done) begin
        bus.if_req = 1'b0;
        got = 1'b1;
      end
    end
    tick();
    check_output("t4 fetch finished", 32'(got), 32'd1);
    check_output("t4 grant count", grant_kind_q.size(), 32'd2);
    if (grant_kind_q.size() >= 2) begin
      check_output("t4 first grant data",   grant_kind_q[0], 32'd1);
      check_output("t4 second grant fetch", grant_kind_q[1], 32'd0);
      check_output("t4 fetch grant timing", grant_cyc_q[1] - d0, 32'd2);
    end

    $display("[TB] test 5: burst limit with both requesters held");
    grant_kind_q.delete(); grant_cyc_q.delete();
    exp_kind = '{1, 1, 1, 1, 0, 1};
    wait_cycles = 1;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0200;
    bus.d_req = 1'b1; bus.d_addr = 32'h0000_2100; bus.d_rw = RW_LOAD; bus.d_size = SIZE_W;
    seen = 0;
    for (int i = 0; i < 200 && seen < 6; i++) begin
      tick();
      if (grant_kind_q.size() != seen) begin
        seen = grant_kind_q.size();
        if (seen == 4) check_output("t5 burst_cnt at 4th grant", 32'(dut.u_arb.burst_cnt), 32'd4);
        if (seen == 5) check_output("t5 burst_cnt after fetch",  32'(dut.u_arb.burst_cnt), 32'd0);
        if (seen == 6) check_output("t5 burst_cnt after 6th",    32'(dut.u_arb.burst_cnt), 32'd1);
      end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    check_output("t5 grants seen", seen, 32'd6);
    for (int k = 0; k < 6 && k < grant_kind_q.size(); k++) begin
      check_output($sformatf("t5 grant %0d kind", k), grant_kind_q[k], exp_kind[k]);
    end
    for (int i = 0; i < 10; i++) tick();
    check_output("t5 drained", 32'(bus.mem_req), 32'd0);

    $display("[TB] test 6: zero-wait memory, alternating requesters");
    ack_mode = 2;
    rdata_val = 32'h5555_AAAA;
    d0 = if_done_cnt + d_done_cnt;
    tick(); tick(); tick();
    check_output("t6 no spurious done", if_done_cnt + d_done_cnt - d0, 32'd0);
    check_output("t6 idle mem_req",     32'(bus.mem_req), 32'd0);
    done_cyc_q.delete();
    d0 = d_done_cnt;
    seen = if_done_cnt;
    c0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
    bus.d_addr = 32'h0000_2010; bus.d_rw = RW_LOAD; bus.d_size = SIZE_W;
    for (int i = 0; i < 60 && done_cyc_q.size() < 6; i++) begin
      tick();
      if (bus.if_done) begin
        bus.if_req = 1'b0;
        bus.d_req  = 1'b1;
      end else if (bus.d_done) begin
        bus.d_req  = 1'b0;
        bus.if_req = 1'b1;
      end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    check_output("t6 done count", done_cyc_q.size(), 32'd6);
    if (done_cyc_q.size() == 6) begin
      check_output("t6 first latency", done_cyc_q[0] - c0, 32'd2);
      for (int k = 1; k < 6; k++) begin
        check_output($sformatf("t6 done spacing %0d", k), done_cyc_q[k] - done_cyc_q[k-1], 32'd3);
      end
    end
    check_output("t6 fetch dones", if_done_cnt - seen, 32'd3);
    check_output("t6 data dones",  d_done_cnt - d0,    32'd3);
    check_output("t6 d_rdata",     bus.d_rdata,        32'h5555_AAAA);
    d0 = if_done_cnt + d_done_cnt;
    tick(); tick(); tick(); tick();
    check_output("t6 quiet after", if_done_cnt + d_done_cnt - d0, 32'd0);
    ack_mode = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
